// File: rtl/wm_actuator_driver.sv
// wm_actuator_driver: actuator-side end of the washing-machine control link.
// Drives the inlet/drain valves, the door-lock solenoid and a soft-ramped
// motor PWM, with safety interlocks. It also reports door-lock status, an
// estimated water level and an interlock fault back to the controller.
// Build option: define WM_ACT_FAULT_LATCH_EN to make `fault` sticky until rst;
// when it is left undefined, `fault` follows the current violations with a
// one-cycle lag.
module wm_actuator_driver #(
  parameter int unsigned PWM_BITS         = 4,
  parameter int unsigned WASH_DUTY        = 8,
  parameter int unsigned RAMP_STEP_CYCLES = 4,
  parameter int unsigned LOCK_DELAY       = 3,
  parameter int unsigned FILL_CYCLES      = 5,
  parameter int unsigned LEVEL_MAX        = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valve_in_cold_cmd,
  input  logic       valve_in_hot_cmd,
  input  logic       valve_out_cmd,
  input  logic [1:0] motor_cmd,
  input  logic       lock_cmd,
  input  logic       doorclosed,
  output logic       cold_drv,
  output logic       hot_drv,
  output logic       drain_drv,
  output logic       motor_pwm,
  output logic       lock_drv,
  output logic       door_locked,
  output logic [3:0] water_level,
  output logic       fault
);

  localparam int unsigned STEP_W  = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int unsigned LOCK_W  = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam int unsigned FILL_W  = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int unsigned LEVEL_W = 4;

  localparam logic [PWM_BITS-1:0] DUTY_WASH = PWM_BITS'(WASH_DUTY);
  localparam logic [PWM_BITS-1:0] DUTY_SPIN = {PWM_BITS{1'b1}};
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST = LOCK_W'(LOCK_DELAY - 1);
  localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(FILL_CYCLES - 1);
  localparam logic [LEVEL_W-1:0]  LVL_TOP   = LEVEL_W'(LEVEL_MAX);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  lock_state_e         lock_state_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic                lock_drv_q;
  logic                door_locked_q;

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] target_c;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                step_wrap_c;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                motor_pwm_q, motor_pwm_d;

  logic                cold_q, cold_d;
  logic                hot_q, hot_d;
  logic                drain_q, drain_d;

  logic [FILL_W-1:0]   lvl_cnt_q, lvl_cnt_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                flow_c, fill_wrap_c;

  logic                door_abort_c;
  logic                lock_viol_c, valve_viol_c, motor_viol_c, viol_c;
  logic                fault_q, fault_d;

  // Door opening while locked aborts the motor on the same edge
  assign door_abort_c = (lock_state_q == LOCKED) && !doorclosed;

  // Door-lock sequencer with registered solenoid drive and lock confirmation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state_q  <= UNLOCKED;
      lock_cnt_q    <= '0;
      lock_drv_q    <= 1'b0;
      door_locked_q <= 1'b0;
    end else begin
      case (lock_state_q)
        UNLOCKED: begin
          if (lock_cmd && doorclosed) begin
            lock_state_q <= LOCKING;
            lock_drv_q   <= 1'b1;
            lock_cnt_q   <= '0;
          end
        end
        LOCKING: begin
          if (!doorclosed || !lock_cmd) begin
            lock_state_q <= UNLOCKED;
            lock_drv_q   <= 1'b0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            lock_state_q  <= LOCKED;
            door_locked_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end
        LOCKED: begin
          // Unlock waits for the motor to spin down; door opening overrides
          if (!doorclosed || (!lock_cmd && (duty_q == '0))) begin
            lock_state_q  <= UNLOCKED;
            lock_drv_q    <= 1'b0;
            door_locked_q <= 1'b0;
          end
        end
        default: begin
          lock_state_q  <= UNLOCKED;
          lock_drv_q    <= 1'b0;
          door_locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Motor target selection and one-step-per-period duty ramp
  always_comb begin
    target_c = '0;
    if (door_locked_q) begin
      case (motor_cmd)
        2'd1:    target_c = DUTY_WASH;
        2'd2:    target_c = DUTY_SPIN;
        default: target_c = '0;
      endcase
    end
    step_wrap_c = (step_cnt_q == STEP_LAST);
    step_cnt_d  = step_wrap_c ? '0 : step_cnt_q + STEP_W'(1);
    duty_d      = duty_q;
    if (door_abort_c) begin
      duty_d = '0;
    end else if (step_wrap_c) begin
      if (duty_q < target_c) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if (duty_q > target_c) begin
        duty_d = duty_q - PWM_BITS'(1);
      end
    end
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    // Compare next count against next duty so the pin tracks the duty register
    motor_pwm_d = (pwm_cnt_d < duty_d);
  end

  // Valve drives: drain wins over inlets, inlets need a closed door
  always_comb begin
    drain_d = valve_out_cmd;
    cold_d  = valve_in_cold_cmd && !valve_out_cmd && doorclosed;
    hot_d   = valve_in_hot_cmd && !valve_out_cmd && doorclosed;
  end

  // Water-level estimate from the currently active valve drives
  always_comb begin
    flow_c      = cold_q || hot_q || drain_q;
    fill_wrap_c = (lvl_cnt_q == FILL_LAST);
    lvl_cnt_d   = '0;
    level_d     = level_q;
    if (flow_c) begin
      lvl_cnt_d = fill_wrap_c ? '0 : lvl_cnt_q + FILL_W'(1);
      if (fill_wrap_c) begin
        if ((cold_q || hot_q) && (level_q < LVL_TOP)) begin
          level_d = level_q + LEVEL_W'(1);
        end else if (drain_q && (level_q != '0)) begin
          level_d = level_q - LEVEL_W'(1);
        end
      end
    end
  end

  // Interlock violations collected into the fault register
  always_comb begin
    valve_viol_c = valve_out_cmd && (valve_in_cold_cmd || valve_in_hot_cmd);
    lock_viol_c  = (lock_state_q != UNLOCKED) && !doorclosed;
    motor_viol_c = (motor_cmd == 2'd3) || ((motor_cmd != 2'd0) && !door_locked_q);
    viol_c       = valve_viol_c || lock_viol_c || motor_viol_c;
`ifdef WM_ACT_FAULT_LATCH_EN
    fault_d = fault_q || viol_c;
`else
    fault_d = viol_c;
`endif
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q      <= '0;
      step_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      motor_pwm_q <= 1'b0;
      cold_q      <= 1'b0;
      hot_q       <= 1'b0;
      drain_q     <= 1'b0;
      lvl_cnt_q   <= '0;
      level_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      step_cnt_q  <= step_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      motor_pwm_q <= motor_pwm_d;
      cold_q      <= cold_d;
      hot_q       <= hot_d;
      drain_q     <= drain_d;
      lvl_cnt_q   <= lvl_cnt_d;
      level_q     <= level_d;
      fault_q     <= fault_d;
    end
  end

  assign cold_drv    = cold_q;
  assign hot_drv     = hot_q;
  assign drain_drv   = drain_q;
  assign motor_pwm   = motor_pwm_q;
  assign lock_drv    = lock_drv_q;
  assign door_locked = door_locked_q;
  assign water_level = level_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_wm_actuator_driver.sv
// Directed self-checking bench for wm_actuator_driver at default parameters.
module tb_wm_actuator_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       valve_in_cold_cmd, valve_in_hot_cmd, valve_out_cmd;
  logic [1:0] motor_cmd;
  logic       lock_cmd, doorclosed;
  logic       cold_drv, hot_drv, drain_drv, motor_pwm, lock_drv, door_locked, fault;
  logic [3:0] water_level;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef WM_ACT_FAULT_LATCH_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  wm_actuator_driver dut (
    .clk(clk), .rst(rst),
    .valve_in_cold_cmd(valve_in_cold_cmd), .valve_in_hot_cmd(valve_in_hot_cmd),
    .valve_out_cmd(valve_out_cmd), .motor_cmd(motor_cmd),
    .lock_cmd(lock_cmd), .doorclosed(doorclosed),
    .cold_drv(cold_drv), .hot_drv(hot_drv), .drain_drv(drain_drv),
    .motor_pwm(motor_pwm), .lock_drv(lock_drv), .door_locked(door_locked),
    .water_level(water_level), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    valve_in_cold_cmd = 1'b0; valve_in_hot_cmd = 1'b0; valve_out_cmd = 1'b0;
    motor_cmd = 2'd0; lock_cmd = 1'b0; doorclosed = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_lock();
    doorclosed = 1'b1;
    lock_cmd   = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (16) begin
      @(negedge clk);
      hi += int'(motor_pwm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cold_drv, hot_drv, drain_drv, motor_pwm, lock_drv, door_locked, fault, water_level} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {cold_drv, hot_drv, drain_drv, motor_pwm, lock_drv, door_locked, fault, water_level});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock_spin();
    int hi;
    apply_reset();
    doorclosed = 1'b1;
    @(negedge clk);
    lock_cmd = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lock_drv !== 1'b1) begin n_fail++; $display("FAIL lock_drv_c1: got %b expected 1", lock_drv); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (door_locked !== 1'b0) begin n_fail++; $display("FAIL door_locked_c3: got %b expected 0", door_locked); end
    @(negedge clk);
    n_checks++;
    if (door_locked !== 1'b1) begin n_fail++; $display("FAIL door_locked_c4: got %b expected 1", door_locked); end
    motor_cmd = 2'd2;
    repeat (64) @(negedge clk);
    count_pwm(hi);
    n_checks++;
    if (hi !== 15) begin n_fail++; $display("FAIL spin_pwm_high: got %0d expected 15", hi); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL spin_fault: got %b expected 0", fault); end
  endtask

  // Continues from full-spin state left by test_lock_spin
  task automatic test_deferred_unlock();
    motor_cmd = 2'd0;
    lock_cmd  = 1'b0;
    repeat (56) @(negedge clk);
    n_checks++;
    if (door_locked !== 1'b1) begin n_fail++; $display("FAIL unlock_deferred: got %b expected 1", door_locked); end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({door_locked, lock_drv} !== 2'b00) begin
      n_fail++; $display("FAIL unlock_done: got %b expected 00", {door_locked, lock_drv});
    end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL unlock_fault: got %b expected 0", fault); end
  endtask

  task automatic test_valve_conflict();
    apply_reset();
    doorclosed = 1'b1;
    valve_in_cold_cmd = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cold_drv, drain_drv, fault} !== 3'b100) begin
      n_fail++; $display("FAIL cold_only: got %b expected 100", {cold_drv, drain_drv, fault});
    end
    valve_out_cmd = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cold_drv, drain_drv, fault} !== 3'b011) begin
      n_fail++; $display("FAIL conflict: got %b expected 011", {cold_drv, drain_drv, fault});
    end
    valve_in_cold_cmd = 1'b0;
    valve_out_cmd = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fault !== STICKY) begin n_fail++; $display("FAIL conflict_clear: got %b expected %b", fault, STICKY); end
    @(negedge clk);
    n_checks++;
    if (fault !== STICKY) begin n_fail++; $display("FAIL conflict_hold: got %b expected %b", fault, STICKY); end
    doorclosed = 1'b0;
    valve_in_hot_cmd = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hot_drv, drain_drv} !== 2'b00) begin
      n_fail++; $display("FAIL hot_door_open: got %b expected 00", {hot_drv, drain_drv});
    end
    apply_reset();
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_after_rst: got %b expected 0", fault); end
  endtask

  task automatic test_door_open();
    int hi;
    apply_reset();
    do_lock();
    motor_cmd = 2'd1;
    repeat (40) @(negedge clk);
    count_pwm(hi);
    n_checks++;
    if (hi !== 8) begin n_fail++; $display("FAIL wash_pwm_high: got %0d expected 8", hi); end
    doorclosed = 1'b0;
    motor_cmd  = 2'd2;
    @(negedge clk);
    n_checks++;
    if ({door_locked, lock_drv, motor_pwm, fault} !== 4'b0001) begin
      n_fail++; $display("FAIL door_open_abort: got %b expected 0001", {door_locked, lock_drv, motor_pwm, fault});
    end
    count_pwm(hi);
    n_checks++;
    if (hi !== 0) begin n_fail++; $display("FAIL door_open_pwm: got %0d expected 0", hi); end
  endtask

  task automatic test_level();
    apply_reset();
    doorclosed = 1'b1;
    valve_in_hot_cmd = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if ({water_level, fault} !== {4'd15, 1'b0}) begin
      n_fail++; $display("FAIL level_full: got level %0d fault %b expected 15 0", water_level, fault);
    end
    valve_in_hot_cmd = 1'b0;
    repeat (3) @(negedge clk);
    valve_out_cmd = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (water_level !== 4'd13) begin n_fail++; $display("FAIL level_drain_mid: got %0d expected 13", water_level); end
    repeat (10) @(negedge clk);
    valve_out_cmd = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (water_level !== 4'd10) begin n_fail++; $display("FAIL level_drain_end: got %0d expected 10", water_level); end
  endtask

  task automatic test_illegal_motor();
    int hi;
    apply_reset();
    do_lock();
    motor_cmd = 2'd1;
    repeat (40) @(negedge clk);
    motor_cmd = 2'd3;
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL illegal_fault: got %b expected 1", fault); end
    repeat (40) @(negedge clk);
    count_pwm(hi);
    n_checks++;
    if (hi !== 0) begin n_fail++; $display("FAIL illegal_ramp_down: got %0d expected 0", hi); end
    n_checks++;
    if (door_locked !== 1'b1) begin n_fail++; $display("FAIL illegal_locked: got %b expected 1", door_locked); end
  endtask

  task automatic test_motor_no_lock();
    int hi;
    apply_reset();
    doorclosed = 1'b1;
    motor_cmd  = 2'd1;
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL nolock_fault: got %b expected 1", fault); end
    repeat (20) @(negedge clk);
    count_pwm(hi);
    n_checks++;
    if (hi !== 0) begin n_fail++; $display("FAIL nolock_pwm: got %0d expected 0", hi); end
  endtask

  task automatic test_reset_mid_ramp();
    apply_reset();
    do_lock();
    motor_cmd = 2'd2;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lock_drv, door_locked, motor_pwm, fault} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: got %b expected 0000", {lock_drv, door_locked, motor_pwm, fault});
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_lock_spin();
    test_deferred_unlock();
    test_valve_conflict();
    test_door_open();
    test_level();
    test_illegal_motor();
    test_motor_no_lock();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wm_actuator_driver.md
# wm_actuator_driver

Actuator-side end of the washing-machine control interface. It takes the controller's valve, motor and door-lock commands and drives the physical actuators with safety interlocks. It soft-ramps the motor through a PWM output, sequences the door-lock solenoid, and returns `door_locked`, `water_level` and `fault` status to the controller.

## Interface
- `PWM_BITS`, 4: PWM counter/duty width; PWM period = 2^PWM_BITS cycles.
- `WASH_DUTY`, 8: target duty for `motor_cmd`=1; must be < 2^PWM_BITS.
- `RAMP_STEP_CYCLES`, 4: cycles per ±1 duty step.
- `LOCK_DELAY`, 3: cycles from `lock_drv` assertion to `door_locked`.
- `FILL_CYCLES`, 5: cycles per ±1 `water_level` step.
- `LEVEL_MAX`, 15: `water_level` saturation value.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `valve_in_cold_cmd`  in  1  cold inlet request.
- `valve_in_hot_cmd`  in  1  hot inlet request.
- `valve_out_cmd`  in  1  drain request.
- `motor_cmd`  in  2  0 off, 1 wash, 2 spin, 3 illegal.
- `lock_cmd`  in  1  door-lock request.
- `doorclosed`  in  1  door switch.
- `cold_drv`, `hot_drv`, `drain_drv`  out  1 each  valve drives.
- `motor_pwm`  out  1  motor PWM.
- `lock_drv`  out  1  lock solenoid.
- `door_locked`  out  1  lock confirmed.
- `water_level`  out  4  estimated level, 0..LEVEL_MAX.
- `fault`  out  1  interlock violation.

## Operation
- All outputs are registered and reset to 0; the lock FSM resets to UNLOCKED; duty and all counters reset to 0.
- Valves, registered one cycle after command:
  - `drain_drv` = `valve_out_cmd`.
  - `cold_drv` = `valve_in_cold_cmd` & !`valve_out_cmd` & `doorclosed`; `hot_drv` likewise. Drain wins.
  - `valve_out_cmd` together with any inlet command raises `fault`.
- Lock FSM, states UNLOCKED, LOCKING, LOCKED:
  - UNLOCKED -> LOCKING on `lock_cmd` & `doorclosed`. Same edge: `lock_drv`=1, delay counter cleared.
  - LOCKING -> LOCKED after LOCK_DELAY cycles in LOCKING. `door_locked`=1 on entry.
  - LOCKING -> UNLOCKED if `lock_cmd` drops (no fault) or `doorclosed` drops (`fault`).
  - LOCKED -> UNLOCKED when `lock_cmd`=0 and duty==0. While duty≠0 it stays LOCKED; unlock is deferred, not refused.
  - LOCKED with `doorclosed`=0 -> UNLOCKED, `fault`, duty forced to 0 on the same edge.
  - `lock_drv`=0 and `door_locked`=0 in UNLOCKED.
- Motor:
  - Target is 0 unless `door_locked`; otherwise 0, WASH_DUTY, or 2^PWM_BITS−1 for `motor_cmd` 0/1/2.
  - `motor_cmd`=3 gives target 0 and `fault`.
  - `motor_cmd`≠0 while not `door_locked` gives `fault`.
  - Step counter runs 0..RAMP_STEP_CYCLES−1. On wrap, duty moves 1 toward target; it holds when equal.
  - A target change does not restart the step counter.
- PWM: free-running `PWM_BITS` counter wraps at 2^PWM_BITS−1; `motor_pwm` = (pwm_cnt < duty), registered. Duty 0 gives constant 0; max duty gives 15/16 high (PWM_BITS=4).
- Water level:
  - The level counter runs 0..FILL_CYCLES−1 while any inlet drive or `drain_drv` is active, and is cleared when none is active.
  - On wrap: +1 if an inlet drive is active, −1 if `drain_drv` is active.
  - Saturates at LEVEL_MAX and 0; saturation is not a fault.
- `fault` register: see Configuration.

## Timing
- Command to valve drive: 1 cycle.
- `lock_cmd` to `lock_drv`: 1 cycle. `lock_cmd` to `door_locked`: LOCK_DELAY+1 cycles.
- Ramp 0 -> full spin (PWM_BITS=4): 15×RAMP_STEP_CYCLES cycles = 60 at default.
- Unlock after spin-down: `door_locked` falls 1 cycle after duty reaches 0.
- Simultaneous events:
  - `doorclosed` fall and `motor_cmd` change on the same cycle: the forced duty 0 wins.
  - Reset mid-ramp: all outputs 0 asynchronously.

## Configuration
- `WM_ACT_FAULT_LATCH_EN`
  - Defined: `fault` is sticky once set and clears only on `rst`.
  - Undefined: `fault` is a registered per-cycle OR of the current violations and clears one cycle after the violation ends.

## Test plan
- Lock/spin/unlock:
  - `doorclosed`=1, `lock_cmd`↑ at cycle 0 -> `lock_drv`=1 at cycle 1, `door_locked`=1 at cycle 4.
  - Then `motor_cmd`=2 -> duty reaches 15 after 60 cycles; `motor_pwm` high 15 of 16 cycles.
- Deferred unlock: at duty 15, `motor_cmd`=0 and `lock_cmd`=0 -> `door_locked` stays 1 for 60 cycles, falls the cycle after duty hits 0; `fault`=0.
- Valve conflict: `valve_in_cold_cmd`=1 and `valve_out_cmd`=1 -> `cold_drv`=0, `drain_drv`=1, `fault`=1. The fault is sticky with `WM_ACT_FAULT_LATCH_EN` and clears one cycle after the conflict ends without it.
- Door opened while washing: LOCKED, duty 8, `doorclosed`↓ -> next cycle duty 0, `motor_pwm`=0, `door_locked`=0, `fault`=1.
- Level model:
  - `valve_in_hot_cmd`=1 for 100 cycles -> `water_level`=15, saturated; no fault.
  - Then `valve_out_cmd` only for 25 cycles -> `water_level`=10.
- Illegal motor command: `motor_cmd`=3 while LOCKED -> duty ramps toward 0, `fault`=1.
- Motor without lock: `motor_cmd`=1 while UNLOCKED -> `motor_pwm` stays 0, `fault`=1.
